// File: rtl/griffin_row_accum_254.sv
// Griffin linear layer row accumulator: tags multiplier issues, sums a
// row of products mod p, adds the round constant and presents it.
module griffin_row_accum_254 #(
   parameter int                N_BITS        = 254,
   parameter logic [N_BITS-1:0] PRIME_MODULUS =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
   parameter int                MULT_LAT      = 5,
   parameter int                ROW_LEN       = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_last,
   output logic              issue_ready,
   input  logic [N_BITS-1:0] rc,
   input  logic [N_BITS-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_BITS-1:0] out_data,
   output logic              len_err
);

   localparam int CNT_W = 8;

   logic [MULT_LAT-1:0] tv_q, tv_d;
   logic [MULT_LAT-1:0] tl_q, tl_d;
   logic [N_BITS-1:0]   acc_q, acc_d;
   logic [N_BITS-1:0]   r1_q, r1_d;
   logic                r1_v_q, r1_v_d;
   logic [N_BITS-1:0]   rc_q, rc_d;
   logic [N_BITS-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                pending_q, pending_d;
   logic                len_err_q, len_err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                accept;
   logic                out_hs;
   logic                tail_v;
   logic                tail_last;
   logic [CNT_W-1:0]    cnt_inc;
   logic [N_BITS-1:0]   sum;

   // operands are canonical, so one conditional subtract reduces the sum
   function automatic logic [N_BITS-1:0] mod_add(
      input logic [N_BITS-1:0] a,
      input logic [N_BITS-1:0] b
   );
      logic [N_BITS:0] s;
      logic [N_BITS:0] pw;
      s  = {1'b0, a} + {1'b0, b};
      pw = {1'b0, PRIME_MODULUS};
      return N_BITS'((s >= pw) ? (s - pw) : s);
   endfunction

   assign issue_ready = ~pending_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign len_err     = len_err_q;

   assign accept    = issue_valid & issue_ready;
   assign out_hs    = out_valid_q & out_ready;
   assign tail_v    = tv_q[MULT_LAT-1];
   assign tail_last = tl_q[MULT_LAT-1];
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign sum       = mod_add(acc_q, prod);

   // tag shift, accumulate, round-constant add, output hold and throttle
   always_comb begin
      tv_d        = tv_q;
      tl_d        = tl_q;
      acc_d       = acc_q;
      r1_d        = r1_q;
      r1_v_d      = 1'b0;
      rc_d        = rc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      pending_d   = pending_q;
      len_err_d   = len_err_q;
      cnt_d       = cnt_q;

      tv_d[0] = accept;
      tl_d[0] = issue_last;
      for (int i = 1; i < MULT_LAT; i++) begin
         tv_d[i] = tv_q[i-1];
         tl_d[i] = tl_q[i-1];
      end

      if (accept && issue_last) begin
         rc_d = rc;
      end

      if (tail_v) begin
         if (tail_last) begin
            r1_d   = sum;
            r1_v_d = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
            if (cnt_inc != CNT_W'(ROW_LEN)) begin
               len_err_d = 1'b1;
            end
         end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(ROW_LEN)) begin
               len_err_d = 1'b1;
            end
         end
      end

      if (out_hs) begin
         out_valid_d = 1'b0;
      end
      if (r1_v_q) begin
         out_data_d  = mod_add(r1_q, rc_q);
         out_valid_d = 1'b1;
      end

      if (out_hs) begin
         pending_d = 1'b0;
      end
      if (accept && issue_last) begin
         pending_d = 1'b1;
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         tv_q        <= '0;
         tl_q        <= '0;
         acc_q       <= '0;
         r1_q        <= '0;
         r1_v_q      <= 1'b0;
         rc_q        <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         pending_q   <= 1'b0;
         len_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         tv_q        <= tv_d;
         tl_q        <= tl_d;
         acc_q       <= acc_d;
         r1_q        <= r1_d;
         r1_v_q      <= r1_v_d;
         rc_q        <= rc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         pending_q   <= pending_d;
         len_err_q   <= len_err_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
